// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit.
// A shift-add multiplier and a restoring divider share one hi:lo accumulator.
// The unit accepts one operation at a time and raises busy while it works.
// It produces one WIDTH-bit result WIDTH+2 cycles after the start cycle.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] babs;
  logic             neg_q;
  logic             rem_neg_q;
  logic             divzero_q;

  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   result;

  // Take operand magnitudes. MUL is treated as unsigned because the low half does not depend on sign.
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    a_abs    = a_neg ? -a : a;
    b_abs    = b_neg ? -b : b;
  end

  // One iteration step: shift-add for multiply, shift and trial-subtract for divide.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, babs} : '0);
    div_sh  = {hi, lo[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, babs};
    div_sub = div_sh[WIDTH-1:0] - babs;
    if (!op_q[2]) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (div_ge) begin
      hi_next = div_sub;
      lo_next = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = div_sh[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Apply the sign to the magnitude result and select the half or the part that op asks for.
  // Divide by zero forces the quotient to all ones. The remainder already equals the dividend.
  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = divzero_q ? '1 : (neg_q ? -lo : lo);
    rem_fix  = rem_neg_q ? -hi : hi;
    case (op_q)
      3'b000:                 result = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         result = quo_fix;
      default:                result = rem_fix;
    endcase
  end

  // Control FSM and datapath registers. Reset has priority over flush, and flush over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      r         <= '0;
      cnt       <= '0;
      op_q      <= '0;
      hi        <= '0;
      lo        <= '0;
      babs      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush && !done) begin
            op_q      <= op;
            hi        <= '0;
            lo        <= a_abs;
            babs      <= b_abs;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            divzero_q <= (b == '0);
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + CNTW'(1);
            if (cnt == LAST_CNT) begin
              state <= FIN;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            r    <= result;
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with one 32-bit instance and one 8-bit instance.
// An arithmetic reference model predicts busy, done and r on every cycle.
// Directed operations also check hand-computed literal results and the latency.
`timescale 1ns/1ps
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;

  logic        start32;
  logic        flush32;
  logic [2:0]  op32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        busy32;
  logic        done32;
  logic [31:0] r32;

  logic        start8;
  logic        flush8;
  logic [2:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  r8;

  int total;
  int bad;

  bit          infl [2];
  int          iss  [2];
  logic [31:0] pend [2];
  logic [31:0] rexp [2];

  alu_muldiv_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .busy(busy32), .done(done32), .r(r32)
  );

  alu_muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .r(r8)
  );

  // Free-running clock with a 10 ns period and the first rising edge at 5 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result for a w-bit RV32M operation, computed with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input int w, input logic [2:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    longint mask, ux, uy, sx, sy, res;
    mask = (longint'(1) << w) - 1;
    ux   = longint'(x) & mask;
    uy   = longint'(y) & mask;
    sx   = (ux >= (longint'(1) << (w - 1))) ? ux - (longint'(1) << w) : ux;
    sy   = (uy >= (longint'(1) << (w - 1))) ? uy - (longint'(1) << w) : uy;
    case (o)
      3'b000:  res = ux * uy;
      3'b001:  res = (sx * sy) >>> w;
      3'b010:  res = (sx * uy) >>> w;
      3'b011:  res = (ux * uy) >>> w;
      3'b100:  res = (uy == 0) ? mask : ((sx == -(longint'(1) << (w - 1)) && sy == -1) ? ux : sx / sy);
      3'b101:  res = (uy == 0) ? mask : ux / uy;
      3'b110:  res = (uy == 0) ? ux : ((sx == -(longint'(1) << (w - 1)) && sy == -1) ? 0 : sx % sy);
      default: res = (uy == 0) ? ux : ux % uy;
    endcase
    return 32'(res & mask);
  endfunction

  function automatic int widthOf(input int sel);
    return (sel == 0) ? 32 : 8;
  endfunction

  function automatic logic doneOf(input int sel);
    return (sel == 0) ? done32 : done8;
  endfunction

  function automatic logic [31:0] rOf(input int sel);
    return (sel == 0) ? r32 : {24'h0, r8};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveStart(input int sel, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (sel == 0) begin
      start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    end else begin
      start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end
  endtask

  task automatic dropStart(input int sel);
    if (sel == 0) start32 = 1'b0;
    else          start8  = 1'b0;
  endtask

  // Wait a bounded number of cycles for done, then check the result and the start-to-done distance.
  task automatic waitDone(input int sel, input string name, input logic [31:0] exp, input int lat0);
    int          lat;
    bit          seen;
    logic [31:0] got;
    lat  = lat0;
    seen = 1'b0;
    got  = '0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(posedge clk); #2;
      dropStart(sel);
      lat++;
      if (doneOf(sel)) begin
        seen = 1'b1;
        got  = rOf(sel);
      end
    end
    checkOutput({name, " done seen"}, 32'(seen), 32'd1);
    checkOutput({name, " result"}, got, exp);
    checkOutput({name, " latency"}, 32'(lat), 32'(widthOf(sel) + 2));
  endtask

  task automatic applyStimulus(input int sel, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] exp, input string name);
    @(posedge clk); #2;
    driveStart(sel, o, x, y);
    waitDone(sel, name, exp, 0);
  endtask

  // Cycle-level model: predicts busy, done and r for both instances at every falling edge.
  initial begin
    int          e;
    int          w;
    bit          bexp;
    bit          dexp;
    logic        bo;
    logic        dn;
    logic        st;
    logic        fl;
    logic [2:0]  o;
    logic [31:0] ro;
    logic [31:0] x;
    logic [31:0] y;
    e = 0;
    forever begin
      @(negedge clk);
      e++;
      for (int s = 0; s < 2; s++) begin
        w = widthOf(s);
        if (s == 0) begin
          bo = busy32; dn = done32; ro = r32; st = start32; fl = flush32; o = op32; x = a32; y = b32;
        end else begin
          bo = busy8; dn = done8; ro = {24'h0, r8}; st = start8; fl = flush8; o = op8;
          x = {24'h0, a8}; y = {24'h0, b8};
        end
        bexp = infl[s] && (e >= iss[s] + 1) && (e <= iss[s] + w + 1);
        dexp = infl[s] && (e == iss[s] + w + 2);
        if (dexp) rexp[s] = pend[s];
        checkOutput($sformatf("w%0d busy cyc%0d", w, e), {31'b0, bo}, {31'b0, bexp});
        checkOutput($sformatf("w%0d done cyc%0d", w, e), {31'b0, dn}, {31'b0, dexp});
        checkOutput($sformatf("w%0d r cyc%0d", w, e), ro, rexp[s]);
        if (!rst_n) begin
          infl[s] = 1'b0;
          rexp[s] = '0;
        end else if (dexp) begin
          infl[s] = 1'b0;
        end else if (bexp && fl) begin
          infl[s] = 1'b0;
        end else if (!bexp && st && !fl) begin
          infl[s] = 1'b1;
          iss[s]  = e;
          pend[s] = model(w, o, x, y);
        end
      end
    end
  end

  // Safety net so the run always ends even if the design locks up.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion, want completion within 30000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    logic [31:0] prev;
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    bit          seen;
    int          dcount;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start32 = 1'b1; flush32 = 1'b0; op32 = 3'b000; a32 = '0; b32 = '0;
    start8  = 1'b1; flush8  = 1'b0; op8  = 3'b000; a8  = '0; b8  = '0;

    $display("[TB] reset held for 2 cycles with start high");
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset busy32", {31'b0, busy32}, 32'd0);
    checkOutput("reset done32", {31'b0, done32}, 32'd0);
    checkOutput("reset r32", r32, 32'd0);
    checkOutput("reset busy8", {31'b0, busy8}, 32'd0);
    checkOutput("reset r8", {24'h0, r8}, 32'd0);
    start32 = 1'b0;
    start8  = 1'b0;
    rst_n   = 1'b1;

    $display("[TB] 32-bit directed operations");
    applyStimulus(0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "MUL 7*-3");
    applyStimulus(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "MULH min*min");
    applyStimulus(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU max*max");
    applyStimulus(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "MULHSU -1*max");
    applyStimulus(0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "DIV -7/2");
    applyStimulus(0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "REM -7/2");
    applyStimulus(0, 3'b101, 32'd100,      32'd7,        32'd14,       "DIVU 100/7");
    applyStimulus(0, 3'b111, 32'd100,      32'd7,        32'd2,        "REMU 100/7");
    applyStimulus(0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, "DIVU 5/0");
    applyStimulus(0, 3'b111, 32'd5,        32'd0,        32'd5,        "REMU 5/0");
    applyStimulus(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV overflow");
    applyStimulus(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "REM overflow");
    applyStimulus(0, 3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, "DIV -7/0");
    applyStimulus(0, 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "REM -7/0");
    applyStimulus(0, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        "REM 7/-2");

    $display("[TB] flush during CALC");
    prev = 32'd1;
    @(posedge clk); #2;
    driveStart(0, 3'b100, 32'd1000, 32'd3);
    @(posedge clk); #2;
    dropStart(0);
    repeat (10) @(posedge clk);
    #2;
    flush32 = 1'b1;
    @(posedge clk); #2;
    flush32 = 1'b0;
    checkOutput("flush busy low", {31'b0, busy32}, 32'd0);
    checkOutput("flush done low", {31'b0, done32}, 32'd0);
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #2;
      if (done32) dcount++;
    end
    checkOutput("flush no done", 32'(dcount), 32'd0);
    checkOutput("flush r kept", r32, prev);

    $display("[TB] start pulsed while busy");
    @(posedge clk); #2;
    driveStart(0, 3'b000, 32'd6, 32'd7);
    @(posedge clk); #2;
    dropStart(0);
    repeat (4) @(posedge clk);
    #2;
    driveStart(0, 3'b101, 32'd9, 32'd3);
    @(posedge clk); #2;
    dropStart(0);
    waitDone(0, "busy start ignored", 32'd42, 6);

    $display("[TB] start held through the done cycle");
    @(posedge clk); #2;
    driveStart(0, 3'b011, 32'hFFFFFFFF, 32'd2);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(posedge clk); #2;
      if (done32) seen = 1'b1;
    end
    checkOutput("held start first done", 32'(seen), 32'd1);
    checkOutput("held start first result", r32, 32'd1);
    @(posedge clk); #2;
    checkOutput("held start ignored in done cycle", {31'b0, busy32}, 32'd0);
    @(posedge clk); #2;
    dropStart(0);
    waitDone(0, "held start reissue", 32'd1, 1);

    $display("[TB] 8-bit directed operations");
    applyStimulus(1, 3'b000, 32'h0F, 32'h0F, 32'hE1, "w8 MUL 0F*0F");
    applyStimulus(1, 3'b011, 32'h0F, 32'h0F, 32'h00, "w8 MULHU 0F*0F");
    applyStimulus(1, 3'b100, 32'h80, 32'hFF, 32'h80, "w8 DIV overflow");
    applyStimulus(1, 3'b110, 32'h80, 32'hFF, 32'h00, "w8 REM overflow");
    applyStimulus(1, 3'b100, 32'hF9, 32'h02, 32'hFD, "w8 DIV -7/2");
    applyStimulus(1, 3'b001, 32'h80, 32'h80, 32'h40, "w8 MULH min*min");

    $display("[TB] mixed operand sweep");
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i % 4 == 1) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      applyStimulus(0, o, x, y, model(32, o, x, y), $sformatf("sweep32 op%0d", o));
      applyStimulus(1, o, x, y, model(8, o, x, y), $sformatf("sweep8 op%0d", o));
    end

    $display("[TB] reset in the middle of an operation");
    @(posedge clk); #2;
    driveStart(0, 3'b000, 32'd3, 32'd5);
    @(posedge clk); #2;
    dropStart(0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    checkOutput("mid reset busy", {31'b0, busy32}, 32'd0);
    checkOutput("mid reset r", r32, 32'd0);
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #2;
      if (done32) dcount++;
    end
    checkOutput("mid reset no done", 32'(dcount), 32'd0);

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative multi-cycle multiply/divide unit implementing the RV32M operation set, parametrised in operand width. It sits beside the single-cycle combinational ALU in the execute stage. It is started by the decode/execute control and stalls the pipeline via busy until done. It produces one WIDTH-bit result per operation using a shift-add multiplier and a restoring divider sharing one accumulator datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, even)
CNTW, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only when busy=0
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  WIDTH  rs1 operand, captured on accepted start
b  in  WIDTH  rs2 operand, captured on accepted start
flush  in  1  abort current operation (pipeline kill)
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse: r valid
r  out  WIDTH  result; held stable until next done

Behaviour:
- One clock; reset is synchronous and active-low: rst_n=0 sampled at a rising clk edge forces state IDLE, busy=0, done=0, r=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, CALC, FIN.
- IDLE: start=1 (busy=0) -> latch op and operands, take absolute values per signedness (MULH: a,b signed; MULHSU: a signed, b unsigned; MUL low half is sign-agnostic; DIV/REM signed; *U unsigned), record result sign, counter=0, go CALC. busy=1 from the next cycle.
- CALC: exactly WIDTH iterations, one bit per cycle. Multiply: 2*WIDTH product register, conditional add of |b| then right shift. Divide: restoring divide, shift remainder:quotient left, trial subtract |b|, set quotient bit if non-negative. Counter increments per cycle; after iteration WIDTH-1 go FIN.
- FIN: apply sign correction (two's complement negate of 2*WIDTH product, quotient, or remainder as required; remainder takes sign of dividend), select low/high half or quotient/remainder, register into r, assert done=1 for this single cycle, busy=0 in the same cycle, next state IDLE.
- Latency: start sampled at edge k -> done=1 in the cycle after edge k+WIDTH+1 (WIDTH+2 cycles start-to-done inclusive), fixed for all ops and operand values.
- start with busy=1: ignored, no queueing. start in the FIN cycle: ignored (busy=0 but done=1 takes priority; control must re-issue); start is accepted only in IDLE.
- Divide by zero (b=0, all divide ops): quotient = all ones, remainder = a (unmodified, signed or unsigned). Same latency.
- Signed overflow (DIV/REM, a = 1<<(WIDTH-1), b = all ones): quotient = a, remainder = 0. Same latency.
- flush=1 in CALC or FIN: next state IDLE, busy=0, done=0 (suppressed even if in FIN), r unchanged. flush in IDLE: no effect; flush and start together in IDLE: flush wins, start ignored.
- rst_n has priority over flush; flush has priority over start.
- r changes only on the done cycle; otherwise holds last value.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, r=0; release, MUL a=7 b=0xFFFFFFFD -> done exactly 34 cycles after start, r=0xFFFFFFEB.
- Multiply high variants: MULH 0x80000000*0x80000000 -> r=0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- Corner cases: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; all at fixed latency.
- Flush/handshake: start DIV, flush at CALC cycle 10 -> busy=0 next cycle, no done, r keeps previous value; start pulsed while busy -> ignored, original result returned.
- WIDTH=8 instance: MUL 0x0F*0x0F -> 0xE1; MULHU -> 0x00; DIV 0x80/0xFF -> 0x80; done 10 cycles after start.
